// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, shared types and the 24->12 bit colour reduction.
package vga_timing_pkg;

   localparam int   DEF_PIX_DIV  = 4;
   localparam int   DEF_H_ACTIVE = 640;
   localparam int   DEF_H_FP     = 16;
   localparam int   DEF_H_SYNC   = 96;
   localparam int   DEF_H_BP     = 48;
   localparam int   DEF_V_ACTIVE = 480;
   localparam int   DEF_V_FP     = 10;
   localparam int   DEF_V_SYNC   = 2;
   localparam int   DEF_V_BP     = 33;
   localparam logic DEF_SYNC_POL = 1'b0;

   localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
   localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

   localparam int CNT_W = 11;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [23:0]      rgb24_t;
   typedef logic [11:0]      rgb12_t;

   // Encoding is {bottom, right} so the select can be built straight from the compares.
   typedef enum logic [1:0] {
      QUAD_TL = 2'd0,
      QUAD_TR = 2'd1,
      QUAD_BL = 2'd2,
      QUAD_BR = 2'd3
   } quad_e;

   function automatic rgb12_t rgb_to_12(input rgb24_t c);
      return {c[23:20], c[15:12], c[7:4]};
   endfunction

   function automatic quad_e quad_of(input logic bottom, input logic right);
      return quad_e'({bottom, right});
   endfunction

endpackage

// File: rtl/vga_quadrant_renderer_if.sv
// Colour inputs and registered video outputs of the quadrant renderer.
interface vga_quadrant_renderer_if;
   import vga_timing_pkg::*;

   rgb24_t rgb0;
   rgb24_t rgb1;
   rgb24_t rgb2;
   rgb24_t rgb3;

   logic   hsync;
   logic   vsync;
   cnt_t   px_h;
   cnt_t   px_v;
   rgb12_t px_12bit_data;
   logic   active;
   logic   frame_start;

   modport master (
      output rgb0, rgb1, rgb2, rgb3,
      input  hsync, vsync, px_h, px_v, px_12bit_data, active, frame_start
   );

   modport slave (
      input  rgb0, rgb1, rgb2, rgb3,
      output hsync, vsync, px_h, px_v, px_12bit_data, active, frame_start
   );

endinterface

// File: rtl/vga_sync_counter.sv
// Pixel-rate divider, h/v raster counters and combinational sync decode.
module vga_sync_counter
   import vga_timing_pkg::*;
#(
   parameter int   PIX_DIV  = DEF_PIX_DIV,
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = DEF_SYNC_POL
) (
   input  logic clk,
   input  logic rst,
   output logic px_en,
   output cnt_t h_cnt,
   output cnt_t v_cnt,
   output logic hsync_raw,
   output logic vsync_raw,
   output logic frame_wrap
);

   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
   localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
   localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             line_wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (px_en) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign px_en      = (div_cnt == DIV_LAST);
   assign line_wrap  = (h_cnt == H_LAST);
   assign frame_wrap = line_wrap && (v_cnt == V_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (px_en) begin
         if (line_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   assign hsync_raw = (h_cnt >= HS_BEG && h_cnt <= HS_END) ? SYNC_POL : ~SYNC_POL;
   assign vsync_raw = (v_cnt >= VS_BEG && v_cnt <= VS_END) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_quadrant_renderer.sv
// Paints four solid quadrants from frame-shadowed colours with registered VGA outputs.
module vga_quadrant_renderer
   import vga_timing_pkg::*;
#(
   parameter int   PIX_DIV  = DEF_PIX_DIV,
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = DEF_SYNC_POL
) (
   input  logic                    clk,
   input  logic                    rst,
   vga_quadrant_renderer_if.slave  vid
);

   localparam cnt_t H_VIS  = cnt_t'(H_ACTIVE);
   localparam cnt_t V_VIS  = cnt_t'(V_ACTIVE);
   localparam cnt_t H_HALF = cnt_t'(H_ACTIVE / 2);
   localparam cnt_t V_HALF = cnt_t'(V_ACTIVE / 2);

   logic   px_en;
   cnt_t   h_cnt;
   cnt_t   v_cnt;
   logic   hsync_raw;
   logic   vsync_raw;
   logic   frame_wrap;

   logic   first_load;
   logic   load_shadow;
   rgb24_t src    [4];
   rgb24_t shadow [4];
   rgb24_t colour [4];
   quad_e  quad;
   rgb24_t pick;
   logic   visible;
   rgb12_t pix_next;

   vga_sync_counter #(
      .PIX_DIV  (PIX_DIV),
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_sync_counter (
      .clk        (clk),
      .rst        (rst),
      .px_en      (px_en),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .hsync_raw  (hsync_raw),
      .vsync_raw  (vsync_raw),
      .frame_wrap (frame_wrap)
   );

   assign src[0] = vid.rgb0;
   assign src[1] = vid.rgb1;
   assign src[2] = vid.rgb2;
   assign src[3] = vid.rgb3;

   // Shadows only change on the last pixel of a frame, or on the very first pixel after reset.
   assign load_shadow = px_en && (first_load || frame_wrap);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= '0;
         end
         first_load <= 1'b1;
      end else if (load_shadow) begin
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= src[i];
         end
         first_load <= 1'b0;
      end
   end

   // The first pixel after reset paints with the colours being loaded in that same cycle.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         colour[i] = first_load ? src[i] : shadow[i];
      end
   end

   always_comb begin
      quad = quad_of(v_cnt >= V_HALF, h_cnt >= H_HALF);
      pick = colour[0];
      unique case (quad)
         QUAD_TL: pick = colour[0];
         QUAD_TR: pick = colour[1];
         QUAD_BL: pick = colour[2];
         QUAD_BR: pick = colour[3];
      endcase
   end

   assign visible  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign pix_next = visible ? rgb_to_12(pick) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         vid.hsync         <= ~SYNC_POL;
         vid.vsync         <= ~SYNC_POL;
         vid.px_h          <= '0;
         vid.px_v          <= '0;
         vid.px_12bit_data <= '0;
         vid.active        <= 1'b0;
         vid.frame_start   <= 1'b0;
      end else begin
         vid.frame_start <= px_en && (h_cnt == '0) && (v_cnt == '0);
         if (px_en) begin
            vid.hsync         <= hsync_raw;
            vid.vsync         <= vsync_raw;
            vid.px_h          <= h_cnt;
            vid.px_v          <= v_cnt;
            vid.px_12bit_data <= pix_next;
            vid.active        <= visible;
         end
      end
   end

endmodule

// File: tb/tb_vga_quadrant_renderer.sv
// Self-checking bench: raster-index reference model checked every clock, plus literal checks.
module tb_vga_quadrant_renderer;

   // Scaled-down geometry keeps a frame to 3360 clks so many frames fit the run.
   localparam int PD  = 4;
   localparam int HA  = 32;
   localparam int HFP = 2;
   localparam int HS  = 4;
   localparam int HBP = 2;
   localparam int VA  = 16;
   localparam int VFP = 1;
   localparam int VS  = 2;
   localparam int VBP = 2;
   localparam int HT  = HA + HFP + HS + HBP;
   localparam int VT  = VA + VFP + VS + VBP;
   localparam int FR  = HT * VT;
   localparam int LIMIT = 2 * FR * PD + 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   vga_quadrant_renderer_if vid();

   vga_quadrant_renderer #(
      .PIX_DIV  (PD),
      .H_ACTIVE (HA),
      .H_FP     (HFP),
      .H_SYNC   (HS),
      .H_BP     (HBP),
      .V_ACTIVE (VA),
      .V_FP     (VFP),
      .V_SYNC   (VS),
      .V_BP     (VBP),
      .SYNC_POL (1'b0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .vid (vid)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int          k = 0;
   bit          model_on = 1'b0;
   logic [23:0] m_sh [4];
   logic        e_hs = 1'b1, e_vs = 1'b1, e_act = 1'b0, e_fs = 1'b0;
   logic [11:0] e_data = '0;
   int          e_h = 0, e_v = 0;

   task automatic model_load();
      m_sh[0] = vid.rgb0;
      m_sh[1] = vid.rgb1;
      m_sh[2] = vid.rgb2;
      m_sh[3] = vid.rgb3;
   endtask

   initial begin
      int q, h, v, qi;
      bit vis;
      forever begin
         @(posedge clk);
         if (rst) begin
            k = 0;
            model_on = 1'b1;
            for (int i = 0; i < 4; i++) m_sh[i] = '0;
         end else begin
            k++;
         end
         if (rst || k < PD) begin
            e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_fs = 1'b0;
            e_data = '0; e_h = 0; e_v = 0;
         end else if (k % PD == 0) begin
            // pixel q of the raster since reset appears on the outputs now
            q = k / PD - 1;
            h = q % HT;
            v = (q / HT) % VT;
            if (q == 0) model_load();
            vis = (h < HA) && (v < VA);
            qi  = ((v >= VA / 2) ? 2 : 0) + ((h >= HA / 2) ? 1 : 0);
            e_data = vis ? {m_sh[qi][23:20], m_sh[qi][15:12], m_sh[qi][7:4]} : 12'h000;
            e_act  = vis;
            e_hs   = !(h >= HA + HFP && h < HA + HFP + HS);
            e_vs   = !(v >= VA + VFP && v < VA + VFP + VS);
            e_h    = h;
            e_v    = v;
            e_fs   = (q % FR == 0);
            if (q % FR == FR - 1) model_load();
         end else begin
            e_fs = 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (model_on) begin
            checks++;
            if (vid.hsync !== e_hs || vid.vsync !== e_vs || vid.active !== e_act ||
                vid.frame_start !== e_fs || vid.px_12bit_data !== e_data ||
                int'(vid.px_h) != e_h || int'(vid.px_v) != e_v) begin
               failures++;
               $display("FAIL cycle k=%0d actual h=%0d v=%0d hs=%b vs=%b act=%b fs=%b data=%h required h=%0d v=%0d hs=%b vs=%b act=%b fs=%b data=%h",
                        k, vid.px_h, vid.px_v, vid.hsync, vid.vsync, vid.active, vid.frame_start,
                        vid.px_12bit_data, e_h, e_v, e_hs, e_vs, e_act, e_fs, e_data);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_fs(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (vid.frame_start !== 1'b1 && n < LIMIT);
      if (vid.frame_start !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL %s timeout waiting for frame_start after %0d clks", name, n);
      end
   endtask

   task automatic wait_pos(input string name, input int h, input int v);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(int'(vid.px_h) == h && int'(vid.px_v) == v) && n < LIMIT);
      if (!(int'(vid.px_h) == h && int'(vid.px_v) == v)) begin
         checks++;
         failures++;
         $display("FAIL %s timeout waiting for (%0d,%0d) after %0d clks", name, h, v, n);
      end
   endtask

   task automatic measure(input bit is_v, output int period, output int low_w);
      int   t = 0, f1 = -1, r1 = -1, f2 = -1;
      logic prev, cur;
      prev = is_v ? vid.vsync : vid.hsync;
      while (f2 < 0 && t < 3 * FR * PD) begin
         @(negedge clk);
         t++;
         cur = is_v ? vid.vsync : vid.hsync;
         if (prev && !cur) begin
            if (f1 < 0) f1 = t;
            else        f2 = t;
         end
         if (!prev && cur && f1 >= 0 && r1 < 0) r1 = t;
         prev = cur;
      end
      period = (f2 >= 0) ? f2 - f1 : -1;
      low_w  = (r1 >= 0) ? r1 - f1 : -1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int per, lw, n;

      // reset and first frame
      rst      = 1'b1;
      vid.rgb0 = 24'hFF0000;
      vid.rgb1 = 24'($urandom);
      vid.rgb2 = 24'($urandom);
      vid.rgb3 = 24'($urandom);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_hsync", int'(vid.hsync), 1);
         chk("rst_vsync", int'(vid.vsync), 1);
         chk("rst_data", int'(vid.px_12bit_data), 0);
      end
      rst = 1'b0;
      wait_fs("first_frame");
      chk("first_px_h", int'(vid.px_h), 0);
      chk("first_px_v", int'(vid.px_v), 0);
      chk("first_data", int'(vid.px_12bit_data), 12'hF00);
      chk("first_active", int'(vid.active), 1);

      // line and frame timing
      measure(1'b0, per, lw);
      chk("hsync_period", per, 160);
      chk("hsync_low", lw, 16);
      measure(1'b1, per, lw);
      chk("vsync_period", per, 3360);
      chk("vsync_low", lw, 320);

      // quadrant mapping and blanking
      vid.rgb0 = 24'h123456;
      vid.rgb1 = 24'hABCDEF;
      vid.rgb2 = 24'h00FF00;
      vid.rgb3 = 24'hF0F0F0;
      wait_fs("quad_frame");
      wait_pos("q_tl_edge", 15, 0);
      chk("q_tl_edge", int'(vid.px_12bit_data), 12'h135);
      wait_pos("q_tr_edge", 16, 0);
      chk("q_tr_edge", int'(vid.px_12bit_data), 12'hACE);
      wait_pos("blank_h", 32, 0);
      chk("blank_h_data", int'(vid.px_12bit_data), 0);
      chk("blank_h_active", int'(vid.active), 0);
      wait_pos("q_bl_edge", 0, 8);
      chk("q_bl_edge", int'(vid.px_12bit_data), 12'h0F0);
      wait_pos("q_br_last", 31, 15);
      chk("q_br_last", int'(vid.px_12bit_data), 12'hFFF);
      chk("q_br_active", int'(vid.active), 1);
      wait_pos("blank_v", 0, 16);
      chk("blank_v_data", int'(vid.px_12bit_data), 0);
      chk("blank_v_active", int'(vid.active), 0);

      // tearing guard
      vid.rgb0 = 24'h000000;
      wait_fs("tear_frame");
      chk("tear_start", int'(vid.px_12bit_data), 12'h000);
      wait_pos("tear_change", 0, 3);
      vid.rgb0 = 24'hFFFFFF;
      wait_pos("tear_row5", 0, 5);
      chk("tear_row5", int'(vid.px_12bit_data), 12'h000);
      wait_pos("tear_row7", 15, 7);
      chk("tear_row7", int'(vid.px_12bit_data), 12'h000);
      wait_fs("tear_next");
      chk("tear_next", int'(vid.px_12bit_data), 12'hFFF);
      n = 0;
      repeat (FR * PD) begin
         @(negedge clk);
         if (vid.frame_start === 1'b1) n++;
      end
      chk("fs_per_frame", n, 1);

      // random colour changes, checked by the model every cycle
      repeat (120) begin
         repeat ($urandom_range(1, 100)) @(negedge clk);
         vid.rgb0 = 24'($urandom);
         vid.rgb1 = 24'($urandom);
         vid.rgb2 = 24'($urandom);
         vid.rgb3 = 24'($urandom);
      end

      // mid-frame reset
      wait_pos("mid_rst_pos", 20, 10);
      rst      = 1'b1;
      vid.rgb0 = 24'h55AA55;
      vid.rgb1 = 24'h0000FF;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_hsync", int'(vid.hsync), 1);
      chk("mid_rst_vsync", int'(vid.vsync), 1);
      chk("mid_rst_data", int'(vid.px_12bit_data), 0);
      chk("mid_rst_px_h", int'(vid.px_h), 0);
      wait_fs("mid_rst_frame");
      chk("mid_rst_new_tl", int'(vid.px_12bit_data), 12'h5A5);
      wait_pos("mid_rst_tr", 16, 0);
      chk("mid_rst_new_tr", int'(vid.px_12bit_data), 12'h00F);
      repeat (50) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
